// File: rtl/mult4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult4_seq_ctrl
//   Sequential 4x4 unsigned shift-and-add multiplier. A single fourBitAdder is
//   reused over four iterations, one per clock, to build an 8-bit product.
//   The requester uses a start/busy/done handshake.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset (has priority over start)
//   start    in   request; accepted only in IDLE or DONE
//   a        in   multiplicand, latched when start is accepted
//   b        in   multiplier, latched when start is accepted
//   busy     out  high while iterating (CALC)
//   done     out  single-cycle completion pulse (DONE)
//   product  out  registered result; held until the next completion or reset
// -----------------------------------------------------------------------------
module mult4_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   m_q;        // multiplicand
    logic [WIDTH-1:0]   q_q;        // multiplier, becomes low product half
    logic [WIDTH-1:0]   a_q;        // accumulator, becomes high product half
    logic               c_q;        // adder carry between add and shift
    logic [1:0]         cnt_q;      // iteration count
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   add_a;
    logic               add_c;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   q_d;

    // Shared adder: accumulator plus multiplicand, add mode only.
    fourBitAdder u_adder (
        .a        (a_q),
        .b        (m_q),
        .Cin0     (1'b0),
        .subtract (1'b0),
        .Cout     (add_cout),
        .sum      (add_sum)
    );

    // Conditional add followed by a one-bit right shift of {C,A,Q}, collapsed
    // into one registered update. The adder carry becomes the new A MSB, so
    // C itself always returns to 0 after each shift.
    always_comb begin
        add_c = q_q[0] ? add_cout : c_q;
        add_a = q_q[0] ? add_sum  : a_q;
        a_d   = {add_c, add_a[WIDTH-1:1]};
        q_d   = {add_a[0], q_q[WIDTH-1:1]};
    end

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values of their neighbours, as real flops do.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= a;
                        q_q     <= b;
                        a_q     <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    c_q   <= 1'b0;
                    cnt_q <= cnt_q + 2'd1;
                    // Fourth iteration: capture the post-shift product directly.
                    if (cnt_q == 2'd3) begin
                        product_q <= {a_d, q_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// -----------------------------------------------------------------------------
// fourBitAdder
//   4-bit ripple adder/subtractor. With subtract=1 the b operand is inverted
//   and an extra carry-in is injected (two's complement subtraction).
//
// Ports
//   a, b      in   operands
//   Cin0      in   carry-in
//   subtract  in   1 = a - b, 0 = a + b + Cin0
//   Cout      out  carry-out
//   sum       out  4-bit result
// -----------------------------------------------------------------------------
module fourBitAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin0,
    input  logic       subtract,
    output logic       Cout,
    output logic [3:0] sum
);

    logic [3:0] b_eff;
    logic       cin;

    assign b_eff       = b ^ {4{subtract}};
    assign cin         = Cin0 | subtract;
    assign {Cout, sum} = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};

endmodule
